// File: rtl/lb_over_scheduler_pkg.sv
// lb_over_scheduler_pkg: status-word layout, control-word bits and scheduler states
package lb_over_scheduler_pkg;
    localparam int SEQ_LSB = 28;
    localparam int SEQ_W = 4;
    localparam int IDX_LSB = 24;
    localparam int IDX_W = 4;
    localparam int STICKY_BIT = 23;
    localparam int SAT_BIT = 22;
    localparam int CNT_LSB = 0;
    localparam int CNT_FW = 16;
    localparam int CTRL_CLR_BIT = 31;
    localparam int CTRL_HOLD_BIT = 30;
    localparam int CTRL_IDX_LSB = 0;
    localparam int CTRL_IDX_W = 4;
    typedef enum logic [1:0] {SCAN, HOLD, CLEAR} state_t;
endpackage

// File: rtl/lb_over_cell.sv
// lb_over_cell: per-source sticky flag and saturating overflow counter
module lb_over_cell #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev,
    input  logic             clr,
    output logic             sticky,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);
    logic full;
    assign full = &cnt;
    // an event landing in the clear cycle survives as the first count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sticky <= 1'b0;
            sat <= 1'b0;
            cnt <= '0;
        end else if (clr) begin
            sticky <= ev;
            sat <= 1'b0;
            cnt <= CNT_W'(ev);
        end else if (ev) begin
            sticky <= 1'b1;
            sat <= sat | full;
            cnt <= full ? cnt : cnt + CNT_W'(1);
        end
endmodule

// File: rtl/lb_over_scheduler.sv
// lb_over_scheduler: time-shares one status register among per-source overflow monitors
module lb_over_scheduler
    import lb_over_scheduler_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16,
    parameter int DWELL = 1024
) (
    input  logic             OPB_Clk,
    input  logic             OPB_Rst_n,
    input  logic [N_SRC-1:0] lb_over_in,
    input  logic [31:0]      ctrl_in,
    output logic [31:0]      user_data_out,
    output logic             busy
);
    state_t state, state_n, mode;
    logic [15:0] dcnt, cnt_ext;
    logic [3:0] idx, cidx, hold_idx, seq_n;
    logic [15:0] sticky_v, sat_v;
    logic [CNT_W-1:0] cnt_v [16];
    logic [31:0] status_n;
    logic prev_clr, clr_req, last, tc, unused_ctrl;

    assign unused_ctrl = ^ctrl_in[29:4];
    assign clr_req = ctrl_in[CTRL_CLR_BIT] ^ prev_clr;
    assign last = cidx == 4'(N_SRC - 1);
    assign tc = dcnt == 16'(DWELL - 1);
    assign hold_idx = {1'b0, ctrl_in[CTRL_IDX_LSB +: CTRL_IDX_W]} >= 5'(N_SRC) ? 4'(N_SRC - 1) : ctrl_in[CTRL_IDX_LSB +: CTRL_IDX_W];
    assign mode = ctrl_in[CTRL_HOLD_BIT] ? HOLD : SCAN;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
        if (!OPB_Rst_n) state <= SCAN;
        else state <= state_n;

    // clear wins over hold changes; a toggle seen mid-sweep is dropped
    always_comb begin
        state_n = (state == CLEAR) ? (last ? mode : CLEAR) : (clr_req ? CLEAR : mode);
    end

    always_comb begin
        busy = state == CLEAR;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
        if (!OPB_Rst_n) begin
            prev_clr <= 1'b0;
            cidx <= '0;
            dcnt <= '0;
            idx <= '0;
        end else begin
            prev_clr <= ctrl_in[CTRL_CLR_BIT];
            cidx <= (busy && !last) ? cidx + 4'd1 : 4'd0;
            if (state == SCAN) begin
                dcnt <= tc ? 16'd0 : dcnt + 16'd1;
                if (tc) idx <= (idx == 4'(N_SRC - 1)) ? 4'd0 : idx + 4'd1;
            end else if (state == HOLD) begin
                dcnt <= '0;
                if (ctrl_in[CTRL_HOLD_BIT]) idx <= hold_idx;
            end
        end

    for (genvar i = 0; i < 16; i++) begin : g_src
        if (i < N_SRC) begin : g_cell
            lb_over_cell #(.CNT_W(CNT_W)) u_cell (
                .clk(OPB_Clk),
                .rst_n(OPB_Rst_n),
                .ev(lb_over_in[i]),
                .clr(busy && cidx == 4'(i)),
                .sticky(sticky_v[i]),
                .sat(sat_v[i]),
                .cnt(cnt_v[i])
            );
        end else begin : g_tie
            assign sticky_v[i] = 1'b0;
            assign sat_v[i] = 1'b0;
            assign cnt_v[i] = '0;
        end
    end

    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = cnt_v[idx];
        seq_n = user_data_out[SEQ_LSB +: SEQ_W] + 4'(idx != user_data_out[IDX_LSB +: IDX_W] || (busy && last));
        status_n = '0;
        status_n[SEQ_LSB +: SEQ_W] = seq_n;
        status_n[IDX_LSB +: IDX_W] = idx;
        status_n[STICKY_BIT] = sticky_v[idx];
        status_n[SAT_BIT] = sat_v[idx];
        status_n[CNT_LSB +: CNT_FW] = cnt_ext;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n)
        if (!OPB_Rst_n) user_data_out <= '0;
        else user_data_out <= status_n;
endmodule

// File: tb/tb_lb_over_scheduler.sv
// tb_lb_over_scheduler: directed tables, corner sequences and a random run against a reference model
module tb_lb_over_scheduler;
    localparam int NS = 4;
    localparam int CW = 2;
    localparam int DW = 8;
    localparam int CMAX = 3;
    localparam logic [31:0] C = 32'h8000_0000;
    localparam logic [31:0] H = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NS-1:0] lb_over_in = '0;
    logic [31:0] ctrl_in = '0;
    logic [31:0] user_data_out;
    logic busy;

    lb_over_scheduler #(.N_SRC(NS), .CNT_W(CW), .DWELL(DW)) dut (
        .OPB_Clk(clk),
        .OPB_Rst_n(rst_n),
        .lb_over_in(lb_over_in),
        .ctrl_in(ctrl_in),
        .user_data_out(user_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    int m_cnt [NS];
    bit m_sticky [NS];
    bit m_sat [NS];
    int m_idx, m_dwell, m_sweep, m_prev;
    bit m_hold;
    logic [31:0] m_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) begin
            m_cnt[s] = 0;
            m_sticky[s] = 0;
            m_sat[s] = 0;
        end
        m_idx = 0;
        m_dwell = 0;
        m_sweep = -1;
        m_prev = 0;
        m_hold = 0;
        m_out = '0;
    endfunction

    // one clock of the reference behaviour; inputs are those present at the edge
    function automatic void m_step(input logic [NS-1:0] ev, input logic [31:0] ctrl);
        bit done;
        bit req;
        int seq;
        int clamp;
        done = (m_sweep == NS - 1);
        seq = int'(m_out[31:28]);
        if (m_idx != int'(m_out[27:24]) || done) seq = (seq + 1) % 16;
        m_out = '0;
        m_out[31:28] = 4'(seq);
        m_out[27:24] = 4'(m_idx);
        m_out[23] = m_sticky[m_idx];
        m_out[22] = m_sat[m_idx];
        m_out[15:0] = 16'(m_cnt[m_idx]);
        for (int s = 0; s < NS; s++) begin
            if (m_sweep == s) begin
                m_cnt[s] = int'(ev[s]);
                m_sticky[s] = ev[s];
                m_sat[s] = 0;
            end else if (ev[s]) begin
                m_sticky[s] = 1;
                if (m_cnt[s] == CMAX) m_sat[s] = 1;
                else m_cnt[s] = m_cnt[s] + 1;
            end
        end
        if (m_sweep < 0) begin
            if (m_hold) begin
                m_dwell = 0;
                clamp = int'(ctrl[3:0]);
                if (ctrl[30]) m_idx = (clamp >= NS) ? NS - 1 : clamp;
            end else if (m_dwell == DW - 1) begin
                m_dwell = 0;
                m_idx = (m_idx + 1) % NS;
            end else m_dwell = m_dwell + 1;
        end
        req = int'(ctrl[31]) != m_prev;
        m_prev = int'(ctrl[31]);
        if (m_sweep >= 0) begin
            if (done) begin
                m_sweep = -1;
                m_hold = ctrl[30];
            end else m_sweep = m_sweep + 1;
        end else if (req) m_sweep = 0;
        else m_hold = ctrl[30];
    endfunction

    task automatic cyc(input logic [NS-1:0] ev, input logic [31:0] ctrl);
        lb_over_in = ev;
        ctrl_in = ctrl;
        @(posedge clk);
        m_step(ev, ctrl);
        #1;
        chk("model", {31'd0, busy, user_data_out}, {31'd0, m_sweep >= 0, m_out});
    endtask

    task automatic do_reset();
        lb_over_in = '0;
        ctrl_in = '0;
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset", {31'd0, busy, user_data_out}, 64'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NS-1:0] ev;
        logic [31:0] ctrl;
        int n;
        logic [31:0] word;
        logic bsy;
    } vec_t;

    vec_t idle_tab [6];
    int b;
    logic [31:0] ctl;

    initial begin
        idle_tab[0] = '{4'h0, 32'h0, 8, 32'h0000_0000, 1'b0};
        idle_tab[1] = '{4'h0, 32'h0, 1, 32'h1100_0000, 1'b0};
        idle_tab[2] = '{4'h0, 32'h0, 7, 32'h1100_0000, 1'b0};
        idle_tab[3] = '{4'h0, 32'h0, 1, 32'h2200_0000, 1'b0};
        idle_tab[4] = '{4'h0, 32'h0, 8, 32'h3300_0000, 1'b0};
        idle_tab[5] = '{4'h0, 32'h0, 8, 32'h4000_0000, 1'b0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            repeat (idle_tab[i].n) cyc(idle_tab[i].ev, idle_tab[i].ctrl);
            chk($sformatf("idle_word%0d", i), {32'd0, user_data_out}, {32'd0, idle_tab[i].word});
            chk($sformatf("idle_busy%0d", i), {63'd0, busy}, {63'd0, idle_tab[i].bsy});
        end

        // saturation on source 2, viewed through hold mode
        do_reset();
        repeat (5) cyc(4'b0100, H | 32'd2);
        repeat (3) cyc(4'b0000, H | 32'd2);
        chk("sat_idx", {60'd0, user_data_out[27:24]}, 64'd2);
        chk("sat_cnt", {48'd0, user_data_out[15:0]}, 64'd3);
        chk("sat_flags", {62'd0, user_data_out[23:22]}, 64'd3);

        // hold with out-of-range index clamps to the last source
        repeat (40) cyc(4'b0000, H | 32'd9);
        chk("hold_idx", {60'd0, user_data_out[27:24]}, 64'd3);
        repeat (9) cyc(4'b0000, 32'd0);
        chk("release_dwell", {60'd0, user_data_out[27:24]}, 64'd3);
        cyc(4'b0000, 32'd0);
        chk("release_next", {60'd0, user_data_out[27:24]}, 64'd0);

        // clear while source 1 pulses
        do_reset();
        repeat (3) cyc(4'b0011, 32'd0);
        b = 0;
        for (int i = 0; i < 10; i++) begin
            cyc((i < 4) ? 4'b0010 : 4'b0000, C);
            b += int'(busy);
        end
        chk("clr_busy_len", 64'(b), 64'd4);
        repeat (4) cyc(4'b0000, C | H | 32'd1);
        chk("clr_src1_cnt", {48'd0, user_data_out[15:0]}, 64'd2);
        chk("clr_src1_flags", {62'd0, user_data_out[23:22]}, 64'd2);
        repeat (4) cyc(4'b0000, C | H | 32'd0);
        chk("clr_src0", {47'd0, user_data_out[23], user_data_out[15:0]}, 64'd0);

        // second toggle during the sweep must not queue another sweep
        b = 0;
        cyc(4'b0000, H);
        b += int'(busy);
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0000, C | H);
            b += int'(busy);
        end
        chk("dbl_toggle_busy", 64'(b), 64'd4);

        // asynchronous reset in the middle of a sweep
        cyc(4'b0000, H);
        cyc(4'b0000, H);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {31'd0, busy, user_data_out}, 64'd0);
        m_reset();
        ctrl_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(4'b0000, 32'd0);
        chk("post_rst", {31'd0, busy, user_data_out[31:24]}, 64'd0);

        // random traffic against the reference model
        do_reset();
        ctl = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ctl[31] = ~ctl[31];
            if ($urandom_range(0, 59) == 0) ctl[30] = ~ctl[30];
            if ($urandom_range(0, 19) == 0) ctl[29:0] = 30'($urandom);
            cyc(4'($urandom) & 4'($urandom), ctl);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
